// File: rtl/vliw_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vliw_fetch_pkg
//  Description : Shared constants, bundle record type and small helpers for
//                the VLIW instruction fetch unit.
//                SLOTS        - instruction slots per bundle
//                BUNDLE_W     - bundle data width in bits (SLOTS*32)
//                BUNDLE_BYTES - PC stride between consecutive bundles
//                NOP_INST     - filler encoding for empty slots
//  Revision    : 1.0  initial release
// ============================================================================
package vliw_fetch_pkg;

    localparam int SLOTS        = 4;
    localparam int BUNDLE_W     = SLOTS * 32;
    localparam int BUNDLE_BYTES = SLOTS * 4;

    localparam logic [31:0]         NOP_INST   = 32'h0000_0013;
    localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = {SLOTS{NOP_INST}};

    // Clears the byte-offset bits so every address lands on a bundle boundary.
    localparam logic [31:0] BUNDLE_ADDR_MASK = ~(32'(BUNDLE_BYTES) - 32'd1);

    typedef struct packed {
        logic [BUNDLE_W-1:0] inst;
        logic [31:0]         pc;
    } bundle_t;

    function automatic logic [31:0] align_bundle(input logic [31:0] addr);
        return addr & BUNDLE_ADDR_MASK;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vliw_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : vliw_fetch_if
//  Description : Instruction-memory request/grant bus between the fetch unit
//                (master) and instruction memory (slave).
//                imem_req    - bundle read request            (master -> slave)
//                imem_addr   - bundle-aligned read address    (master -> slave)
//                imem_gnt    - request accepted this cycle    (slave -> master)
//                imem_rvalid - response valid, 1 cycle after grant
//                imem_rdata  - bundle data, slot i at [32i+31:32i]
//  Revision    : 1.0  initial release
// ============================================================================
interface vliw_fetch_if;
    import vliw_fetch_pkg::*;

    logic                imem_req;
    logic [31:0]         imem_addr;
    logic                imem_gnt;
    logic                imem_rvalid;
    logic [BUNDLE_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/vliw_fetch_bundle_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_bundle_queue
//  Description : 2-entry FIFO of fetched bundles. Flush has priority over
//                push and pop; a push into a full queue is accepted only when
//                a pop happens in the same cycle.
//  Ports       : clk, rst (sync, active-low)
//                i_push/i_data  - enqueue request and bundle
//                i_pop          - dequeue the head
//                i_flush        - drop all entries at the end of the cycle
//                o_head         - head entry (meaningless while o_empty)
//                o_full/o_empty/o_count - occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_bundle_queue
    import vliw_fetch_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst,
    input  wire logic    i_push,
    input  wire bundle_t i_data,
    input  wire logic    i_pop,
    input  wire logic    i_flush,
    output bundle_t      o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic [1:0]   o_count
);

    bundle_t    r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop & (r_count != 2'd0);
    assign w_do_push = i_push & ((r_count != 2'd2) | w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
        end
    end

    // Storage needs no reset: it is only observed through a non-zero count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/vliw_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : vliw_fetch
//  Description : VLIW instruction fetch unit. Owns the fetch PC, issues
//                bundle reads over the imem request/grant bus, buffers
//                responses in a 2-entry queue and presents one bundle per
//                cycle to the issue stage. A taken branch redirects the PC,
//                flushes the queue and squashes the presented bundle.
//  Ports       : clk, rst (sync, active-low)
//                stall         - hold the presented bundle
//                branch_taken  - redirect request, target on new_pc
//                imem          - vliw_fetch_if master modport
//                bundle_inst   - presented bundle (NOPs when empty)
//                bundle_pc     - PC of slot 0 (holds last value when empty)
//                bundle_valid  - presented bundle is real
//                branch_squash - presented bundle is wrong-path
//  Options     : VLIW_FETCH_PERF_EN adds saturating 32-bit counters
//                perf_bundles, perf_redirects and perf_empty.
//  Revision    : 1.0  initial release
// ============================================================================
module vliw_fetch
    import vliw_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          stall,
    input  wire logic          branch_taken,
    input  wire logic [31:0]   new_pc,
    vliw_fetch_if.master       imem,
    output logic [BUNDLE_W-1:0] bundle_inst,
    output logic [31:0]        bundle_pc,
    output logic               bundle_valid,
    output logic               branch_squash
`ifdef VLIW_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_bundles,
    output logic [31:0]        perf_redirects,
    output logic [31:0]        perf_empty
`endif
);

    logic [31:0] r_fpc;
    logic [31:0] r_resp_pc;
    logic [31:0] r_last_pc;
    logic        r_outstanding;

    bundle_t     w_head;
    bundle_t     w_push_data;
    logic        w_full;
    logic        w_empty;
    logic [1:0]  w_count;
    logic        w_pop;
    logic        w_push;
    logic        w_grant;
    logic [2:0]  w_level;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign w_pop = bundle_valid & ~stall;

    // Entries held plus the one in flight, minus the one leaving this
    // cycle; a new request is only made when its response has a slot.
    assign w_level = 3'(w_count) + 3'(r_outstanding) - 3'(w_pop);

    assign imem.imem_req  = rst & (w_level < 3'd2);
    assign imem.imem_addr = branch_taken ? align_bundle(new_pc) : r_fpc;
    assign w_grant        = imem.imem_req & imem.imem_gnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fpc         <= RESET_PC;
            r_outstanding <= 1'b0;
            r_resp_pc     <= RESET_PC;
        end else begin
            r_outstanding <= w_grant;
            if (w_grant) begin
                r_resp_pc <= imem.imem_addr;
            end
            if (branch_taken) begin
                // The redirect address itself may already be granted.
                r_fpc <= align_bundle(new_pc)
                         + (w_grant ? 32'(BUNDLE_BYTES) : 32'd0);
            end else if (w_grant) begin
                r_fpc <= r_fpc + 32'(BUNDLE_BYTES);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response side / bundle queue
    // ------------------------------------------------------------------
    // Gating on r_outstanding drops a response whose grant predates a reset.
    // Responses in a redirect cycle belong to the wrong path.
    assign w_push = imem.imem_rvalid & r_outstanding & ~branch_taken
                    & (~w_full | w_pop);

    assign w_push_data.inst = imem.imem_rdata;
    assign w_push_data.pc   = r_resp_pc;

    fetch_bundle_queue u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (branch_taken),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // ------------------------------------------------------------------
    // Presentation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_pc <= RESET_PC;
        end else if (!w_empty) begin
            r_last_pc <= w_head.pc;
        end
    end

    assign bundle_valid  = ~w_empty;
    assign bundle_inst   = w_empty ? NOP_BUNDLE : w_head.inst;
    assign bundle_pc     = w_empty ? r_last_pc  : w_head.pc;
    assign branch_squash = branch_taken;

`ifdef VLIW_FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_bundles   <= 32'd0;
            perf_redirects <= 32'd0;
            perf_empty     <= 32'd0;
        end else begin
            if (w_pop) begin
                perf_bundles <= sat_inc(perf_bundles);
            end
            if (branch_taken) begin
                perf_redirects <= sat_inc(perf_redirects);
            end
            if (!bundle_valid && !stall) begin
                perf_empty <= sat_inc(perf_empty);
            end
        end
    end
`endif

endmodule
`default_nettype wire
